// File: rtl/xy_display_if.sv
// Bundles the processor result registers and the display-side outputs of the XY sequencer.
interface xy_display_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [31:0]                   V0;
    logic [31:0]                   V1;
    logic [31:0]                   X;
    logic [31:0]                   Y;
    logic                          displayXY;
    logic                          Overflow;
    logic [$clog2(FIFO_DEPTH):0]   Count;

    modport master (
        output V0, V1,
        input  X, Y, displayXY, Overflow, Count
    );

    modport slave (
        input  V0, V1,
        output X, Y, displayXY, Overflow, Count
    );
endinterface

// File: rtl/xy_display_sequencer.sv
// Queues each new {V1,V0} result pair and shows it on X/Y for at least DWELL_CYCLES cycles.
// S_IDLE | no pair dwelling, pop as soon as the queue holds one ; S_DWELL | current pair held until the dwell counter reaches 0
module xy_display_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    xy_display_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [DW_W-1:0]  DWELL_RELOAD = DW_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
    localparam logic [DW_W-1:0]  DW_ONE       = DW_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_prev_v0;
    logic [31:0]        r_prev_v1;
    logic [63:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DW_W-1:0]    r_dwell;
    logic [31:0]        r_x;
    logic [31:0]        r_y;
    logic               r_display;
    logic               r_overflow;

    logic               w_event;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [63:0]        w_head;

    assign w_event = (bus.V0 != r_prev_v0) || (bus.V1 != r_prev_v1);
    // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
    assign w_push  = w_event && ((r_count != CNT_FULL) || w_pop);
    assign w_drop  = w_event && !w_push;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (r_dwell == '0) begin
                    if (r_count != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.V1, bus.V0};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_prev_v0  <= '0;
            r_prev_v1  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dwell    <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_display  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prev_v0 <= bus.V0;
            r_prev_v1 <= bus.V1;
            r_display <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_x      <= w_head[63:32];
                r_y      <= w_head[31:0];
                r_dwell  <= DWELL_RELOAD;
            end else if (r_dwell != '0) begin
                r_dwell  <= r_dwell - DW_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.X         = r_x;
    assign bus.Y         = r_y;
    assign bus.displayXY = r_display;
    assign bus.Overflow  = r_overflow;
    assign bus.Count     = r_count;
endmodule

// File: tb/tb_xy_display_sequencer.sv
// Directed bench for xy_display_sequencer with a queue-based reference model checked every cycle.
module tb_xy_display_sequencer;
    localparam int DWELL = 4;
    localparam int DEPTH = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    xy_display_if #(.FIFO_DEPTH(DEPTH)) bus ();

    xy_display_sequencer #(
        .DWELL_CYCLES (DWELL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pop may happen once DWELL edges have passed since the previous pop.
    logic [63:0] mq[$];
    logic [31:0] m_prev0 = '0, m_prev1 = '0, m_x = '0, m_y = '0;
    bit          m_disp = 0, m_ovf = 0, m_ev;
    int          m_age = DWELL;
    logic [63:0] m_pair;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mq.delete();
            m_prev0 = '0; m_prev1 = '0; m_x = '0; m_y = '0;
            m_disp = 0; m_ovf = 0; m_age = DWELL;
        end else begin
            m_ev = (bus.V0 != m_prev0) || (bus.V1 != m_prev1);
            m_prev0 = bus.V0;
            m_prev1 = bus.V1;
            if (m_age < DWELL) m_age++;
            if (m_age >= DWELL && mq.size() > 0) begin
                m_pair = mq.pop_front();
                m_x = m_pair[63:32];
                m_y = m_pair[31:0];
                m_disp = 1;
                m_age = 0;
            end else begin
                m_disp = 0;
            end
            if (m_ev) begin
                if (mq.size() < DEPTH) mq.push_back({bus.V1, bus.V0});
                else m_ovf = 1;
            end
        end
    end

    int          cyc = 0;
    int          pulse_cyc[$];
    logic [31:0] pulse_x[$];
    logic [31:0] pulse_y[$];
    int          peak = 0;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        chk("model_X", bus.X, m_x);
        chk("model_Y", bus.Y, m_y);
        chk("model_displayXY", bus.displayXY, m_disp);
        chk("model_Overflow", bus.Overflow, m_ovf);
        chk("model_Count", bus.Count, mq.size());
        if (bus.displayXY) begin
            pulse_cyc.push_back(cyc);
            pulse_x.push_back(bus.X);
            pulse_y.push_back(bus.Y);
        end
        if (int'(bus.Count) > peak) peak = int'(bus.Count);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_x.delete();
        pulse_y.delete();
        peak = 0;
    endtask

    task automatic start_clean();
        Reset = 1'b0;
        bus.V0 = '0;
        bus.V1 = '0;
        tick(2);
        clear_log();
        Reset = 1'b1;
    endtask

    function automatic logic [31:0] px(input int i);
        return (i < pulse_x.size()) ? pulse_x[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] py(input int i);
        return (i < pulse_y.size()) ? pulse_y[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bus.V0 = 32'd5;
        bus.V1 = 32'd7;
        tick(2);
        chk("rst_X", bus.X, 0);
        chk("rst_Y", bus.Y, 0);
        chk("rst_disp", bus.displayXY, 0);
        chk("rst_Count", bus.Count, 0);
        chk("rst_Ovf", bus.Overflow, 0);
        clear_log();
        Reset = 1'b1;
        tick(1);
        chk("rel_capture_Count", bus.Count, 1);
        chk("rel_capture_disp", bus.displayXY, 0);
        tick(1);
        chk("rel_X", bus.X, 7);
        chk("rel_Y", bus.Y, 5);
        chk("rel_disp", bus.displayXY, 1);
        tick(1);
        chk("rel_disp_drop", bus.displayXY, 0);
        tick(5);
        chk("rel_pulses", pulse_x.size(), 1);

        // Steady input held across reset release
        Reset = 1'b0;
        bus.V0 = 32'd3;
        bus.V1 = 32'd9;
        tick(1);
        clear_log();
        Reset = 1'b1;
        tick(20);
        chk("steady_pulses", pulse_x.size(), 1);
        chk("steady_X", bus.X, 9);
        chk("steady_Y", bus.Y, 3);
        chk("steady_Count", bus.Count, 0);

        // Three back-to-back changes spaced by the dwell
        start_clean();
        for (int k = 0; k < 3; k++) begin
            bus.V0 = 32'(2 * k + 1);
            bus.V1 = 32'(2 * k + 2);
            tick(1);
        end
        tick(15);
        chk("dwell_pulses", pulse_x.size(), 3);
        if (pulse_cyc.size() == 3) begin
            chk("dwell_gap1", pulse_cyc[1] - pulse_cyc[0], 4);
            chk("dwell_gap2", pulse_cyc[2] - pulse_cyc[1], 4);
        end
        for (int k = 0; k < 3; k++) begin
            chk("dwell_seq_X", px(k), 32'(2 * k + 2));
            chk("dwell_seq_Y", py(k), 32'(2 * k + 1));
        end
        chk("dwell_Ovf", bus.Overflow, 0);

        // Seven pairs on consecutive edges: the sixth lands on a pop edge, the seventh is dropped
        start_clean();
        for (int k = 1; k <= 7; k++) begin
            bus.V0 = 32'h100 + 32'(k);
            bus.V1 = 32'h200 + 32'(k);
            tick(1);
            if (k == 6) begin
                chk("fullpop_Count", bus.Count, 4);
                chk("fullpop_Ovf", bus.Overflow, 0);
            end
            if (k == 7) begin
                chk("ovf_first_drop", bus.Overflow, 1);
                chk("ovf_Count", bus.Count, 4);
            end
        end
        tick(40);
        chk("ovf_peak", peak, 4);
        chk("ovf_pulses", pulse_x.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("ovf_seq_X", px(k), 32'h201 + 32'(k));
            chk("ovf_seq_Y", py(k), 32'h101 + 32'(k));
        end
        chk("ovf_sticky", bus.Overflow, 1);

        // Full FIFO accepting a pair on the pop edge, then draining without overflow
        start_clean();
        for (int k = 1; k <= 6; k++) begin
            bus.V0 = 32'h500 + 32'(k);
            bus.V1 = 32'h600 + 32'(k);
            tick(1);
        end
        chk("fullpop2_Count", bus.Count, 4);
        chk("fullpop2_Ovf", bus.Overflow, 0);
        tick(40);
        chk("fullpop2_pulses", pulse_x.size(), 6);
        chk("fullpop2_last_X", bus.X, 32'h606);
        chk("fullpop2_Ovf_end", bus.Overflow, 0);

        // Asynchronous reset with three pairs queued
        start_clean();
        for (int k = 1; k <= 4; k++) begin
            bus.V0 = 32'h300 + 32'(k);
            bus.V1 = 32'h400 + 32'(k);
            tick(1);
        end
        chk("mid_pre_Count", bus.Count, 3);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_X", bus.X, 0);
        chk("mid_Y", bus.Y, 0);
        chk("mid_disp", bus.displayXY, 0);
        chk("mid_Count", bus.Count, 0);
        chk("mid_Ovf", bus.Overflow, 0);
        bus.V0 = '0;
        bus.V1 = '0;
        tick(2);
        clear_log();
        Reset = 1'b1;
        tick(20);
        chk("mid_no_old_pairs", pulse_x.size(), 0);
        chk("mid_X_after", bus.X, 0);
        chk("mid_Count_after", bus.Count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xy_display_sequencer.md
Name: xy_display_sequencer

Overview:
- Sits between the processor core (`top2`) and the 8-digit seven-segment driver. Runs in the divided clock domain (ClkOut).
- Watches the processor's V0/V1 result registers every cycle. Each time the pair changes, it queues the new pair.
- Presents queued pairs to the display as X/Y. Each pair is held for a minimum dwell time so fast-changing results stay readable.
- Overflow is flagged when the processor produces pairs faster than they can be displayed.

Parameters:
- DWELL_CYCLES, 4, minimum number of Clk cycles each displayed pair is held (must be ≥1).
- FIFO_DEPTH, 4, number of pending pairs that can be queued (power of 2, ≥2).

Ports:
- Clk  input  1  system clock (driven by ClkOut of the clock divider).
- Reset  input  1  asynchronous, active-low reset.
- V0  input  32  processor result register $v0, sampled every rising edge.
- V1  input  32  processor result register $v1, sampled every rising edge.
- X  output  32  displayed value for the left 4 digits (from V1 of the pair).
- Y  output  32  displayed value for the right 4 digits (from V0 of the pair).
- displayXY  output  1  one-cycle pulse on the cycle X/Y take a new pair.
- Overflow  output  1  sticky flag: a pair was dropped because the FIFO was full.
- Count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low. While Reset=0, all of the following are cleared immediately:
  - X=0, Y=0, displayXY=0, Overflow=0, Count=0.
  - prevV0=0, prevV1=0, FIFO pointers=0, dwell counter=0, state=IDLE.
- Reset asserted mid-operation discards queued pairs and any dwell in progress.
- Change detection, at each rising edge:
  - event = (V0!=prevV0) || (V1!=prevV1).
  - prevV0/prevV1 are then loaded with V0/V1.
  - A first pair of all zeros after reset generates no event.
  - A value held steady produces exactly one event.
- Push: on an event, {V1,V0} is written at the FIFO tail if the FIFO is not full after this cycle's pop.
  - Otherwise the pair is discarded and Overflow is set to 1. It stays 1 until reset.
- Pop/state machine, two states:
  - IDLE:
    - If Count>0: pop the head into X (V1 half) and Y (V0 half), pulse displayXY=1, load dwell counter with DWELL_CYCLES-1, go to DWELL.
    - Else hold X/Y and stay in IDLE.
    - A pair pushed at edge k into an empty FIFO appears on X/Y after edge k+1.
  - DWELL:
    - If counter>0: decrement, X/Y hold.
    - If counter==0 and Count>0: pop the next pair at this edge (back-to-back), pulse displayXY, reload the counter, stay in DWELL.
    - If counter==0 and Count==0: go to IDLE; X/Y keep the last pair.
    - Each displayed pair is therefore held exactly DWELL_CYCLES cycles when the queue is backed up.
    - With DWELL_CYCLES=1, pairs pop on consecutive cycles.
- Simultaneous push and pop:
  - Both happen in the same edge, so Count is unchanged.
  - When the FIFO is full, a same-cycle pop frees a slot and the push is accepted (no overflow).
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count saturates at neither end: push-when-full and pop-when-empty never occur by construction.
- displayXY is 0 on every cycle without a pop.
- Outputs are registered; no combinational path from V0/V1 to X/Y.

Test Plan:
- Reset hold: Reset=0 with V0=5, V1=7 -> X=Y=0, displayXY=0, Count=0. Release; the next edge captures the event. After one more edge X=7, Y=5, and displayXY pulses for 1 cycle.
- Steady input: V0=3, V1=9 held for 20 cycles after reset -> exactly one displayXY pulse, X=9, Y=3 remain. Count returns to 0.
- Dwell spacing (DWELL_CYCLES=4): change pairs on 3 consecutive cycles (1/2, 3/4, 5/6) -> displayXY pulses exactly 4 cycles apart. X/Y show 2/1, then 4/3, then 6/5. Overflow=0.
- Overflow (FIFO_DEPTH=4): 7 distinct pairs on consecutive cycles while the first is dwelling -> Count peaks at 4, Overflow=1 at the first drop. Displayed sequence omits the dropped pairs; Overflow stays 1 afterwards.
- Full-plus-pop: FIFO full, and a new pair arrives on the same edge the dwell counter hits 0 -> pair accepted, Count stays 4, Overflow stays 0.
- Mid-dwell reset: assert Reset=0 asynchronously (between edges) with Count=3 -> all outputs 0 immediately. After release, old pairs never appear.
